// File: rtl/tis_node_datapath_gen.sv
// rtl/tis_node_datapath_gen.sv - execution datapath for one TIS-style compute node
//
// Holds ACC/BAK and executes one decoded instruction at a time (MOV, ADD, SUB,
// NEG, SWP, SAV, NOP) against NPORTS blocking neighbour ports.
// Optional build macro: TIS_SAT_EN selects symmetric saturating ADD/SUB/NEG
// (range +/-(2^(DW-1)-1)); when undefined, arithmetic wraps modulo 2^DW.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   instr_valid, op             decoded instruction, held until instr_done
//   src_sel, dst_sel, imm       operand selectors and immediate
//   instr_done                  combinational commit strobe
//   in_data/in_valid/in_ready   neighbour read channels (in_ready combinational)
//   out_data/out_valid/out_ready neighbour write channels (registered)
//   acc                         ACC value
//   last_port, last_valid       port resolved by the most recent ANY
//   stalled                     instr_valid and not instr_done
module tis_node_datapath_gen #(
    parameter int DW     = 8,
    parameter int NPORTS = 4,
    parameter int SELW   = $clog2(NPORTS + 5)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    input  logic [2:0]                op,
    input  logic [SELW-1:0]           src_sel,
    input  logic [SELW-1:0]           dst_sel,
    input  logic [DW-1:0]             imm,
    output logic                      instr_done,
    input  logic [NPORTS*DW-1:0]      in_data,
    input  logic [NPORTS-1:0]         in_valid,
    output logic [NPORTS-1:0]         in_ready,
    output logic [NPORTS*DW-1:0]      out_data,
    output logic [NPORTS-1:0]         out_valid,
    input  logic [NPORTS-1:0]         out_ready,
    output logic [DW-1:0]             acc,
    output logic [$clog2(NPORTS)-1:0] last_port,
    output logic                      last_valid,
    output logic                      stalled
);
    localparam int PW = $clog2(NPORTS);

    localparam logic [2:0] OP_MOV = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_NEG = 3'd3;
    localparam logic [2:0] OP_SWP = 3'd4;
    localparam logic [2:0] OP_SAV = 3'd5;

    // Selector codes above the port range; IMM (source) and BAK (destination)
    // share the same code.
    localparam logic [SELW-1:0] SEL_ACC  = SELW'(NPORTS);
    localparam logic [SELW-1:0] SEL_IMM  = SELW'(NPORTS + 1);
    localparam logic [SELW-1:0] SEL_BAK  = SELW'(NPORTS + 1);
    localparam logic [SELW-1:0] SEL_ANY  = SELW'(NPORTS + 3);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NPORTS + 4);

    typedef enum logic {S_EXEC, S_WR} state_t;

    state_t          state;
    logic [DW-1:0]   bak;
    logic            wr_any;
    logic [PW-1:0]   wr_port;

    logic            exec_act;
    logic            need_src;
    logic            rd_port_en;
    logic            rd_any;
    logic            any_hit;
    logic [PW-1:0]   rd_port;
    logic [PW-1:0]   any_port;
    logic            src_ok;
    logic [DW-1:0]   src_val;
    logic            dst_port_en;
    logic            dst_any;
    logic [PW-1:0]   dst_port;
    logic            mov_to_port;
    logic            wr_hit;
    logic [PW-1:0]   wr_grant;
    logic [DW-1:0]   add_res;
    logic [DW-1:0]   sub_res;
    logic [DW-1:0]   neg_res;

    assign exec_act    = !rst && (state == S_EXEC) && instr_valid;
    assign need_src    = (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB);
    assign mov_to_port = (op == OP_MOV) && dst_port_en;

    // Source resolution. A port source is only "ok" once its neighbour has a word.
    always_comb begin
        rd_port_en = 1'b0;
        rd_any     = 1'b0;
        rd_port    = '0;
        src_val    = '0;
        if (src_sel < SEL_ACC) begin
            rd_port_en = 1'b1;
            rd_port    = src_sel[PW-1:0];
        end else if (src_sel == SEL_ACC) begin
            src_val = acc;
        end else if (src_sel == SEL_IMM) begin
            src_val = imm;
        end else if (src_sel == SEL_ANY) begin
            rd_any = 1'b1;
        end else if (src_sel == SEL_LAST) begin
            // LAST without a recorded port reads like NIL
            rd_port_en = last_valid;
            rd_port    = last_port;
        end

        // Downward scan so the lowest-index valid port is the one left standing.
        any_hit  = 1'b0;
        any_port = '0;
        for (int p = NPORTS - 1; p >= 0; p--) begin
            if (in_valid[p]) begin
                any_hit  = 1'b1;
                any_port = PW'(p);
            end
        end
        if (rd_any) begin
            rd_port_en = any_hit;
            rd_port    = any_port;
        end

        src_ok = !(rd_any && !any_hit);
        if (rd_port_en) begin
            src_ok = 1'b0;
            for (int p = 0; p < NPORTS; p++) begin
                if (rd_port == PW'(p)) begin
                    src_ok  = in_valid[p];
                    src_val = in_data[p*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (exec_act && need_src && rd_port_en) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (rd_port == PW'(p)) in_ready[p] = in_valid[p];
            end
        end
    end

    always_comb begin
        dst_port_en = 1'b0;
        dst_any     = 1'b0;
        dst_port    = '0;
        if (dst_sel < SEL_ACC) begin
            dst_port_en = 1'b1;
            dst_port    = dst_sel[PW-1:0];
        end else if (dst_sel == SEL_ANY) begin
            dst_port_en = 1'b1;
            dst_any     = 1'b1;
        end else if (dst_sel == SEL_LAST) begin
            dst_port_en = last_valid;
            dst_port    = last_port;
        end
    end

    // ANY-write grant: lowest-index neighbour accepting.
    always_comb begin
        wr_hit   = 1'b0;
        wr_grant = '0;
        for (int p = NPORTS - 1; p >= 0; p--) begin
            if (out_ready[p]) begin
                wr_hit   = 1'b1;
                wr_grant = PW'(p);
            end
        end
    end

    always_comb begin
        instr_done = 1'b0;
        if (!rst && (state == S_WR)) begin
            instr_done = wr_any ? wr_hit : out_ready[wr_port];
        end else if (exec_act) begin
            instr_done = need_src ? (src_ok && !mov_to_port) : 1'b1;
        end
    end

    assign stalled = instr_valid && !instr_done;

`ifdef TIS_SAT_EN
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SNEG = SMIN | {{(DW-1){1'b0}}, 1'b1};

    function automatic logic [DW-1:0] sat(input logic [DW:0] s);
        logic signed [DW:0] ss;
        ss = $signed(s);
        if (ss > $signed({1'b0, SMAX})) return SMAX;
        if (ss < $signed({1'b1, SNEG})) return SNEG;
        return s[DW-1:0];
    endfunction

    logic [DW-1:0] arith_in;
    logic [DW:0]   acc_x;
    logic [DW:0]   in_x;

    // Sums are formed one bit wider so overflow is visible before clamping.
    always_comb begin
        arith_in = (src_val == SMIN) ? SNEG : src_val;
        acc_x    = {acc[DW-1], acc};
        in_x     = {arith_in[DW-1], arith_in};
        add_res  = sat(acc_x + in_x);
        sub_res  = sat(acc_x - in_x);
        neg_res  = sat({(DW+1){1'b0}} - acc_x);
    end
`else
    always_comb begin
        add_res = acc + src_val;
        sub_res = acc - src_val;
        neg_res = -acc;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_EXEC;
            acc        <= '0;
            bak        <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            last_port  <= '0;
            last_valid <= 1'b0;
            wr_any     <= 1'b0;
            wr_port    <= '0;
        end else begin
            case (state)
                S_EXEC: begin
                    if (instr_valid) begin
                        if (need_src && rd_any && any_hit) begin
                            last_port  <= any_port;
                            last_valid <= 1'b1;
                        end
                        case (op)
                            OP_MOV: begin
                                if (src_ok) begin
                                    if (dst_port_en) begin
                                        state   <= S_WR;
                                        wr_any  <= dst_any;
                                        wr_port <= dst_port;
                                        for (int p = 0; p < NPORTS; p++) begin
                                            if (dst_any || (dst_port == PW'(p))) begin
                                                out_data[p*DW +: DW] <= src_val;
                                                out_valid[p]         <= 1'b1;
                                            end
                                        end
                                    end else if (dst_sel == SEL_ACC) begin
                                        acc <= src_val;
                                    end else if (dst_sel == SEL_BAK) begin
                                        bak <= src_val;
                                    end
                                end
                            end
                            OP_ADD: if (src_ok) acc <= add_res;
                            OP_SUB: if (src_ok) acc <= sub_res;
                            OP_NEG: acc <= neg_res;
                            OP_SWP: begin
                                acc <= bak;
                                bak <= acc;
                            end
                            OP_SAV: bak <= acc;
                            default: ;
                        endcase
                    end
                end
                S_WR: begin
                    if (instr_done) begin
                        state     <= S_EXEC;
                        out_valid <= '0;
                        // Non-granted ANY targets see their valid drop here (retraction).
                        if (wr_any) begin
                            last_port  <= wr_grant;
                            last_valid <= 1'b1;
                        end
                    end
                end
                default: state <= S_EXEC;
            endcase
        end
    end
endmodule

// File: tb/tb_tis_node_datapath_gen.sv
// tb/tb_tis_node_datapath_gen.sv - self-checking bench for tis_node_datapath_gen
module tb_tis_node_datapath_gen;
    localparam int DW     = 8;
    localparam int NPORTS = 4;
    localparam int SELW   = 4;

    localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, NEG = 3'd3;
    localparam logic [2:0] SWP = 3'd4, SAV = 3'd5, NOP = 3'd6, NOP7 = 3'd7;
    localparam logic [3:0] P0 = 4'd0, P1 = 4'd1, P2 = 4'd2;
    localparam logic [3:0] ACC = 4'd4, IMM = 4'd5, BAK = 4'd5, NIL = 4'd6, ANY = 4'd7, LAST = 4'd8;

    typedef struct packed {
        logic [2:0] o;
        logic [3:0] s;
        logic [3:0] d;
        logic [7:0] i;
    } instr_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 instr_valid;
    logic [2:0]           op;
    logic [SELW-1:0]      src_sel;
    logic [SELW-1:0]      dst_sel;
    logic [DW-1:0]        imm;
    logic                 instr_done;
    logic [NPORTS*DW-1:0] in_data;
    logic [NPORTS-1:0]    in_valid;
    logic [NPORTS-1:0]    in_ready;
    logic [NPORTS*DW-1:0] out_data;
    logic [NPORTS-1:0]    out_valid;
    logic [NPORTS-1:0]    out_ready;
    logic [DW-1:0]        acc;
    logic [1:0]           last_port;
    logic                 last_valid;
    logic                 stalled;

    tis_node_datapath_gen #(.DW(DW), .NPORTS(NPORTS), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op),
        .src_sel(src_sel), .dst_sel(dst_sel), .imm(imm), .instr_done(instr_done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .last_port(last_port), .last_valid(last_valid), .stalled(stalled)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int ir_cnt [NPORTS];
    int ov_cnt [NPORTS];
    int st_cnt;
    logic [7:0]  exp_acc_q [$];
    logic [10:0] exp_wr_q [$];
    logic [10:0] got_wr_q [$];
    logic [7:0]  m_acc;
    logic [7:0]  m_bak;

    // Reference arithmetic on plain integers.
    function automatic logic [7:0] m_fit(input int v);
        int r;
        r = v;
`ifdef TIS_SAT_EN
        if (r > 127) r = 127;
        if (r < -127) r = -127;
`endif
        return r[7:0];
    endfunction

    function automatic int m_in(input logic [7:0] b);
        int v;
        v = int'($signed(b));
`ifdef TIS_SAT_EN
        if (v == -128) v = -127;
`endif
        return v;
    endfunction

    function automatic logic [7:0] m_add(input logic [7:0] a, input logic [7:0] b);
        return m_fit(int'($signed(a)) + m_in(b));
    endfunction

    function automatic logic [7:0] m_sub(input logic [7:0] a, input logic [7:0] b);
        return m_fit(int'($signed(a)) - m_in(b));
    endfunction

    function automatic logic [7:0] m_neg(input logic [7:0] a);
        return m_fit(-int'($signed(a)));
    endfunction

    // Presents one instruction from a negedge, samples once per cycle until
    // instr_done, and logs every write handshake into got_wr_q.
    task automatic run_instr(input logic [2:0] o, input logic [3:0] s, input logic [3:0] d,
                             input logic [7:0] i, output int cyc);
        bit done;
        bit wr_seen;
        for (int p = 0; p < NPORTS; p++) begin
            ir_cnt[p] = 0;
            ov_cnt[p] = 0;
        end
        st_cnt = 0;
        cyc    = 0;
        done   = 1'b0;
        @(negedge clk);
        instr_valid = 1'b1;
        op = o; src_sel = s; dst_sel = d; imm = i;
        while (!done) begin
            #2;
            cyc++;
            st_cnt += int'(stalled);
            wr_seen = 1'b0;
            for (int p = 0; p < NPORTS; p++) begin
                ir_cnt[p] += int'(in_ready[p]);
                ov_cnt[p] += int'(out_valid[p]);
                if (!wr_seen && out_valid[p] && out_ready[p] && instr_done) begin
                    got_wr_q.push_back({3'(p), out_data[p*8 +: 8]});
                    wr_seen = 1'b1;
                end
            end
            if (instr_done === 1'b1) begin
                done = 1'b1;
            end else if (cyc >= 60) begin
                n_vec++; n_bad++;
                $display("FAIL timeout: instr_done low for %0d cycles, required within 60", cyc);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b1; op = MOV; src_sel = P0; dst_sel = ACC; imm = 8'h55;
        in_valid = 4'hF; out_ready = 4'hF; in_data = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        #2;
        n_vec++; if (acc !== 8'h00) begin n_bad++; $display("FAIL reset_acc: got %h want 00", acc); end
        n_vec++; if (out_valid !== 4'h0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0000", out_valid); end
        n_vec++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if (in_ready !== 4'h0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        n_vec++; if (instr_done !== 1'b0) begin n_bad++; $display("FAIL reset_instr_done: got %b want 0", instr_done); end
        n_vec++; if (last_valid !== 1'b0 || last_port !== 2'd0) begin
            n_bad++; $display("FAIL reset_last: got %b/%0d want 0/0", last_valid, last_port);
        end
        instr_valid = 1'b0; in_valid = '0; out_ready = '0; in_data = '0;
        @(negedge clk);
        rst = 1'b0;
        m_acc = 8'h00; m_bak = 8'h00;
    endtask

    task automatic test_reg_ops();
        instr_t tbl [13];
        instr_t t;
        int cyc;
        int act;
        logic [7:0] v;
        logic [7:0] e;
        tbl[0]  = '{MOV, IMM, ACC, 8'h05};
        tbl[1]  = '{ADD, IMM, P2,  8'h03};
        tbl[2]  = '{SAV, IMM, ACC, 8'h00};
        tbl[3]  = '{SUB, IMM, ANY, 8'h0A};
        tbl[4]  = '{SWP, NIL, NIL, 8'h00};
        tbl[5]  = '{NEG, P1,  P1,  8'h00};
        tbl[6]  = '{NOP, IMM, ACC, 8'h77};
        tbl[7]  = '{MOV, ACC, BAK, 8'h00};
        tbl[8]  = '{ADD, ACC, ACC, 8'h00};
        tbl[9]  = '{SWP, ACC, ACC, 8'h00};
        tbl[10] = '{MOV, NIL, ACC, 8'h99};
        tbl[11] = '{NOP7, IMM, ACC, 8'h12};
        tbl[12] = '{SWP, ACC, ACC, 8'h00};
        act = 0;
        for (int k = 0; k < 13; k++) begin
            t = tbl[k];
            v = (t.s == IMM) ? t.i : (t.s == ACC) ? m_acc : 8'h00;
            case (t.o)
                MOV: begin
                    if (t.d == ACC) m_acc = v;
                    else if (t.d == BAK) m_bak = v;
                end
                ADD: m_acc = m_add(m_acc, v);
                SUB: m_acc = m_sub(m_acc, v);
                NEG: m_acc = m_neg(m_acc);
                SWP: begin v = m_acc; m_acc = m_bak; m_bak = v; end
                SAV: m_bak = m_acc;
                default: ;
            endcase
            exp_acc_q.push_back(m_acc);
            run_instr(t.o, t.s, t.d, t.i, cyc);
            e = exp_acc_q.pop_front();
            n_vec++; if (acc !== e) begin n_bad++; $display("FAIL reg_op[%0d]_acc: got %h want %h", k, acc, e); end
            n_vec++; if (cyc !== 1) begin n_bad++; $display("FAIL reg_op[%0d]_latency: got %0d want 1", k, cyc); end
            for (int p = 0; p < NPORTS; p++) act += ir_cnt[p] + ov_cnt[p];
        end
        n_vec++; if (act !== 0) begin n_bad++; $display("FAIL reg_ops_port_activity: got %0d want 0", act); end
    endtask

    task automatic test_port_read();
        int cyc;
        logic [7:0] e;
        in_data[15:8] = 8'h2A;
        m_acc = 8'h2A;
        exp_acc_q.push_back(m_acc);
        fork
            run_instr(MOV, P1, ACC, 8'h00, cyc);
            begin
                repeat (4) @(negedge clk);
                in_valid[1] = 1'b1;
                @(posedge clk);
                #1;
                in_valid[1] = 1'b0;
            end
        join
        e = exp_acc_q.pop_front();
        n_vec++; if (acc !== e) begin n_bad++; $display("FAIL port_read_acc: got %h want %h", acc, e); end
        n_vec++; if (st_cnt !== 3) begin n_bad++; $display("FAIL port_read_stall: got %0d want 3", st_cnt); end
        n_vec++; if (ir_cnt[1] !== 1) begin n_bad++; $display("FAIL port_read_in_ready: got %0d want 1", ir_cnt[1]); end
        n_vec++; if (cyc !== 4) begin n_bad++; $display("FAIL port_read_latency: got %0d want 4", cyc); end
    endtask

    task automatic test_port_write();
        int cyc;
        logic [10:0] g;
        logic [10:0] e;
        run_instr(MOV, IMM, ACC, 8'h11, cyc);
        m_acc = 8'h11;
        exp_wr_q.push_back({3'd2, 8'h11});
        fork
            run_instr(MOV, ACC, P2, 8'h00, cyc);
            begin
                repeat (5) @(negedge clk);
                out_ready[2] = 1'b1;
                @(posedge clk);
                #1;
                out_ready[2] = 1'b0;
            end
        join
        n_vec++; if (cyc !== 5) begin n_bad++; $display("FAIL port_write_latency: got %0d want 5", cyc); end
        n_vec++; if (ov_cnt[2] !== 4) begin n_bad++; $display("FAIL port_write_valid_cycles: got %0d want 4", ov_cnt[2]); end
        n_vec++; if (ov_cnt[0] + ov_cnt[1] + ov_cnt[3] !== 0) begin
            n_bad++; $display("FAIL port_write_other_ports: got %0d want 0", ov_cnt[0] + ov_cnt[1] + ov_cnt[3]);
        end
        e = exp_wr_q.pop_front();
        g = (got_wr_q.size() != 0) ? got_wr_q.pop_front() : 11'h7FF;
        n_vec++; if (g !== e) begin n_bad++; $display("FAIL port_write_handshake: got %h want %h", g, e); end
        n_vec++; if (out_valid !== 4'h0) begin n_bad++; $display("FAIL port_write_valid_clear: got %b want 0000", out_valid); end
        n_vec++; if (acc !== m_acc) begin n_bad++; $display("FAIL port_write_acc: got %h want %h", acc, m_acc); end
    endtask

    task automatic test_any();
        int cyc;
        logic [10:0] g;
        logic [10:0] e;
        logic [7:0]  ea;
        in_data = {8'h07, 8'h00, 8'h09, 8'h00};
        in_valid = 4'b1010;
        m_acc = 8'h09;
        exp_acc_q.push_back(m_acc);
        run_instr(MOV, ANY, ACC, 8'h00, cyc);
        in_valid = 4'b0000;
        ea = exp_acc_q.pop_front();
        n_vec++; if (acc !== ea) begin n_bad++; $display("FAIL any_read_acc: got %h want %h", acc, ea); end
        n_vec++; if (ir_cnt[1] !== 1 || ir_cnt[3] !== 0) begin
            n_bad++; $display("FAIL any_read_in_ready: got p1=%0d p3=%0d want 1/0", ir_cnt[1], ir_cnt[3]);
        end
        n_vec++; if (last_port !== 2'd1 || last_valid !== 1'b1) begin
            n_bad++; $display("FAIL any_read_last: got %0d/%b want 1/1", last_port, last_valid);
        end

        out_ready = 4'b1111;
        exp_wr_q.push_back({3'd1, 8'h09});
        run_instr(MOV, ACC, LAST, 8'h00, cyc);
        out_ready = 4'b0000;
        n_vec++; if (ov_cnt[1] !== 1 || ov_cnt[0] + ov_cnt[2] + ov_cnt[3] !== 0) begin
            n_bad++; $display("FAIL last_write_ports: got p1=%0d others=%0d want 1/0", ov_cnt[1], ov_cnt[0] + ov_cnt[2] + ov_cnt[3]);
        end
        e = exp_wr_q.pop_front();
        g = (got_wr_q.size() != 0) ? got_wr_q.pop_front() : 11'h7FF;
        n_vec++; if (g !== e) begin n_bad++; $display("FAIL last_write_handshake: got %h want %h", g, e); end
        n_vec++; if (cyc !== 2) begin n_bad++; $display("FAIL last_write_latency: got %0d want 2", cyc); end

        exp_wr_q.push_back({3'd2, 8'h33});
        fork
            run_instr(MOV, IMM, ANY, 8'h33, cyc);
            begin
                repeat (3) @(negedge clk);
                out_ready = 4'b0100;
                @(posedge clk);
                #1;
                out_ready = 4'b0000;
            end
        join
        n_vec++; if (ov_cnt[0] !== 2 || ov_cnt[3] !== 2) begin
            n_bad++; $display("FAIL any_write_broadcast: got p0=%0d p3=%0d want 2/2", ov_cnt[0], ov_cnt[3]);
        end
        e = exp_wr_q.pop_front();
        g = (got_wr_q.size() != 0) ? got_wr_q.pop_front() : 11'h7FF;
        n_vec++; if (g !== e) begin n_bad++; $display("FAIL any_write_handshake: got %h want %h", g, e); end
        n_vec++; if (last_port !== 2'd2) begin n_bad++; $display("FAIL any_write_last_port: got %0d want 2", last_port); end
        n_vec++; if (out_valid !== 4'h0) begin n_bad++; $display("FAIL any_write_retract: got %b want 0000", out_valid); end
    endtask

    task automatic test_arith_edge();
        instr_t tbl [7];
        int cyc;
        logic [7:0] e;
        tbl[0] = '{MOV, IMM, ACC, 8'h7F};
        tbl[1] = '{ADD, IMM, ACC, 8'h01};
        tbl[2] = '{MOV, IMM, ACC, 8'h81};
        tbl[3] = '{NEG, NIL, ACC, 8'h00};
        tbl[4] = '{MOV, IMM, ACC, 8'h00};
        tbl[5] = '{ADD, IMM, ACC, 8'h80};
        tbl[6] = '{SUB, IMM, ACC, 8'h01};
        for (int k = 0; k < 7; k++) begin
            case (tbl[k].o)
                MOV: m_acc = tbl[k].i;
                ADD: m_acc = m_add(m_acc, tbl[k].i);
                SUB: m_acc = m_sub(m_acc, tbl[k].i);
                NEG: m_acc = m_neg(m_acc);
                default: ;
            endcase
            exp_acc_q.push_back(m_acc);
            run_instr(tbl[k].o, tbl[k].s, tbl[k].d, tbl[k].i, cyc);
            e = exp_acc_q.pop_front();
            n_vec++; if (acc !== e) begin n_bad++; $display("FAIL arith[%0d]_acc: got %h want %h", k, acc, e); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [10:0] g;
        logic [10:0] e;
        in_data[7:0] = 8'h44;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        exp_wr_q.push_back({3'd0, 8'h44});
        run_instr(MOV, P0, P0, 8'h00, cyc);
        in_valid = '0;
        out_ready = '0;
        n_vec++; if (cyc !== 2) begin n_bad++; $display("FAIL p2p_latency: got %0d want 2", cyc); end
        n_vec++; if (ir_cnt[0] !== 1) begin n_bad++; $display("FAIL p2p_in_ready: got %0d want 1", ir_cnt[0]); end
        e = exp_wr_q.pop_front();
        g = (got_wr_q.size() != 0) ? got_wr_q.pop_front() : 11'h7FF;
        n_vec++; if (g !== e) begin n_bad++; $display("FAIL p2p_handshake: got %h want %h", g, e); end
    endtask

    task automatic test_reset_in_wr();
        int cyc;
        logic [7:0] e;
        run_instr(MOV, IMM, ACC, 8'h5A, cyc);
        @(negedge clk);
        instr_valid = 1'b1; op = MOV; src_sel = ACC; dst_sel = P0;
        out_ready = '0;
        @(negedge clk);
        #2;
        n_vec++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h5A) begin
            n_bad++; $display("FAIL wr_pending: got %b/%h want 1/5a", out_valid[0], out_data[7:0]);
        end
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 4'h0) begin n_bad++; $display("FAIL rst_in_wr_valid: got %b want 0000", out_valid); end
        n_vec++; if (acc !== 8'h00) begin n_bad++; $display("FAIL rst_in_wr_acc: got %h want 00", acc); end
        n_vec++; if (instr_done !== 1'b0) begin n_bad++; $display("FAIL rst_in_wr_done: got %b want 0", instr_done); end
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_acc = 8'h00; m_bak = 8'h00;

        m_acc = 8'h03;
        exp_acc_q.push_back(m_acc);
        run_instr(MOV, IMM, ACC, 8'h03, cyc);
        e = exp_acc_q.pop_front();
        n_vec++; if (acc !== e || cyc !== 1) begin
            n_bad++; $display("FAIL post_reset_instr: got %h/%0d want %h/1", acc, cyc, e);
        end

        in_data[15:8] = 8'h66;
        in_valid[1] = 1'b1;
        m_acc = 8'h00;
        exp_acc_q.push_back(m_acc);
        run_instr(MOV, LAST, ACC, 8'h00, cyc);
        in_valid = '0;
        e = exp_acc_q.pop_front();
        n_vec++; if (acc !== e || ir_cnt[1] !== 0) begin
            n_bad++; $display("FAIL last_as_nil: got %h/%0d want %h/0", acc, ir_cnt[1], e);
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; op = '0; src_sel = '0; dst_sel = '0; imm = '0;
        in_data = '0; in_valid = '0; out_ready = '0;
        m_acc = 8'h00; m_bak = 8'h00;
        test_reset();
        test_reg_ops();
        test_port_read();
        test_port_write();
        test_any();
        test_arith_edge();
        test_back_to_back();
        test_reset_in_wr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/tis_node_datapath_gen.md
Name: tis_node_datapath_gen

Overview:
- Parametrised next-generation execution datapath for one TIS-style compute node.
- Holds ACC/BAK and executes one decoded instruction at a time: MOV, ADD, SUB, NEG, SWP, SAV, NOP.
- Supports NPORTS blocking neighbour ports with valid/ready handshakes, plus ANY/LAST port modes.
- Sits between the node instruction sequencer, which holds instr_valid until instr_done, and the mesh links.

Parameters:
DW, 8, data/ACC/BAK width
NPORTS, 4, number of neighbour ports (2..8)
SELW, $clog2(NPORTS+5), width of src_sel/dst_sel

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction present; held stable until instr_done
op  in  3  0 MOV, 1 ADD, 2 SUB, 3 NEG, 4 SWP, 5 SAV, 6/7 NOP
src_sel  in  SELW  0..NPORTS-1 port; NPORTS ACC; +1 IMM; +2 NIL; +3 ANY; +4 LAST
dst_sel  in  SELW  0..NPORTS-1 port; NPORTS ACC; +1 BAK; +2 NIL; +3 ANY; +4 LAST
imm  in  DW  immediate operand
instr_done  out  1  combinational commit strobe; sequencer advances on this edge
in_data  in  NPORTS*DW  port p at [p*DW +: DW]
in_valid  in  NPORTS  neighbour has a word
in_ready  out  NPORTS  combinational take strobe
out_data  out  NPORTS*DW  registered write data
out_valid  out  NPORTS  registered write pending
out_ready  in  NPORTS  neighbour accepts
acc  out  DW  ACC value
last_port  out  $clog2(NPORTS)  port resolved by the most recent ANY
last_valid  out  1  last_port meaningful
stalled  out  1  instr_valid and not instr_done

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async, immediate effect):
  - Registers: ACC=0, BAK=0, state=EXEC.
  - Ports: out_valid=0, out_data=0.
  - LAST tracking: last_valid=0, last_port=0.
  - Strobes: instr_done=0, in_ready=0.
  - Reset mid-write drops out_valid in the same cycle; the word is lost.
- FSM states: EXEC, WR.
- EXEC with instr_valid:
  - Source resolution:
    - Register/IMM/NIL source resolves immediately; NIL reads 0.
    - Port p source: in_ready[p]=in_valid[p]. Transfer completes when both are high; otherwise stall with no state change.
    - ANY source: lowest-index port with in_valid; only that port gets in_ready. Sets last_port to that port and last_valid=1 at the edge.
    - LAST source: reads port last_port if last_valid; otherwise acts as NIL.
  - Ops:
    - MOV: value -> dst.
    - ADD/SUB: ACC ± value -> ACC; dst is ignored.
    - NEG: ACC = -ACC.
    - SWP: ACC<->BAK.
    - SAV: BAK=ACC.
    - NOP: nothing.
    - NEG/SWP/SAV/NOP ignore src; they complete in 1 cycle with no port activity.
  - Destination:
    - Non-port dst (ACC, BAK, NIL, or LAST with last_valid=0): commit at the edge; instr_done=1 this cycle.
    - Port dst (p, ANY, or LAST with last_valid=1): latch value into out_data of the target port(s) and go to WR; instr_done stays 0.
- WR:
  - out_valid=1 on the target port, or on all ports for ANY.
  - Complete in the cycle the target's out_ready=1: instr_done=1, then return to EXEC and clear out_valid at the edge.
  - ANY write: grant goes to the lowest-index port with out_ready. Record last_port/last_valid=1; all other out_valid drop together. Non-granted neighbours must treat a dropped valid as a retraction.
- Latency:
  - Register op: 1 cycle.
  - Port read to register: 1 cycle plus wait for in_valid.
  - Any port write: at least 2 cycles.
- Arithmetic: two's-complement DW bits, wraps modulo 2^DW.
- A simultaneous in_valid and out_ready on one port in one cycle is legal; they are independent channels.
- A MOV from port p to port p is legal: read first, then write.
- instr_valid low in EXEC: nothing changes and all strobes stay 0.
- Changing instruction fields while stalled is illegal and unchecked.

Optional Feature:
- TIS_SAT_EN defined:
  - ADD, SUB and NEG saturate to the symmetric range ±(2^(DW-1)-1).
  - -2^(DW-1) is never produced; it clamps to -(2^(DW-1)-1).
  - IMM/port values equal to -2^(DW-1) are clamped on entry to arithmetic.
- Not defined: plain wrap-around.

Test Plan:
- Reset, then MOV IMM=5->ACC, ADD IMM=3 -> instr_done each cycle; acc=8; no in_ready/out_valid activity.
- MOV port1->ACC with in_valid[1] raised 3 cycles late, data 0x2A -> stalled for 3 cycles; in_ready[1] pulses once; acc=0x2A.
- MOV ACC(0x11)->port2, out_ready[2] after 4 cycles -> out_valid[2] high 4 cycles, out_data[2]=0x11; instr_done coincides with the handshake.
- MOV ANY->ACC with in_valid=4'b1010 (data3=7, data1=9) -> port1 taken; acc=9; last_port=1; then MOV ACC->LAST writes to port1 only.
- ACC=0x7F, ADD IMM=1 -> acc=0x80 without TIS_SAT_EN, 0x7F with it. ACC=0x81, NEG -> 0x7F in both builds.
- Assert rst while in WR with out_valid[0]=1 -> out_valid=0 immediately; acc=0; FSM in EXEC; first instruction after reset executes normally.
